regs_wb_arb: RTL
================

REGS_WB_ARB -- requirements
Module: regs_wb_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive denied dbg cycles before dbg is promoted above lsu/mdu.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ex_we_i / ex_waddr_i / ex_wdata_i  input  1/5/32  single-cycle ALU writeback; no handshake, always accepted.
REQ-005 lsu_valid_i / lsu_waddr_i / lsu_wdata_i  input  1/5/32  load writeback request; lsu_ready_o output 1 grant.
REQ-006 mdu_valid_i / mdu_waddr_i / mdu_wdata_i  input  1/5/32  mul/div writeback request; mdu_ready_o output 1 grant.
REQ-007 dbg_valid_i / dbg_waddr_i / dbg_wdata_i  input  1/5/32  debug-bus register write request; dbg_ready_o output 1 grant.
REQ-008 issue_lock_i / issue_addr_i  input  1/5  long-latency op issued; mark issue_addr_i busy.
REQ-009 rs1_i / rs2_i / rd_i  input  5/5/5  decode-stage operand query.
REQ-010 flush_i  input  1  pipeline flush; clears scoreboard.
REQ-011 hazard_o  output  1  combinational; operand or destination busy.
REQ-012 we_o / waddr_o / wdata_o  output  1/5/32  single regfile write port.
REQ-013 busy_o  output  32  scoreboard vector; bit 0 always 0.

Function
REQ-014 At most one requester SHALL be granted per cycle; a handshake completes when valid and ready are both high in the same cycle.
REQ-015 Priority SHALL be ex > (lsu/mdu round-robin) > dbg, except dbg is promoted per REQ-018.
REQ-016 ready outputs SHALL be combinational from current valids and registered state; ready SHALL be 0 whenever ex_we_i=1.
REQ-017 Round-robin pointer rr (0=lsu first, 1=mdu first) SHALL toggle only when lsu or mdu is granted, pointing away from the granted one; a sole requester is granted regardless of rr.
REQ-018 Counter starve (width clog2(STARVE_MAX)+1) SHALL increment, saturating, each cycle dbg_valid_i=1 and dbg not granted; clear on dbg grant or dbg_valid_i=0; when starve==STARVE_MAX dbg outranks lsu/mdu (never ex).
REQ-019 Write port SHALL be zero-latency: waddr_o/wdata_o = granted requester's address/data; we_o=1 iff a grant (or ex_we_i) and waddr nonzero.
REQ-020 Writes to x0 SHALL complete the handshake with we_o=0 and no scoreboard effect.
REQ-021 Idle (no grant): we_o=0, waddr_o=0, wdata_o=0.
REQ-022 issue_lock_i with nonzero addr SHALL set busy[addr] at next edge.
REQ-023 Accepted lsu or mdu write SHALL clear busy[waddr] at next edge; ex and dbg writes SHALL NOT change busy.
REQ-024 Same-cycle set and clear of the same bit: set wins.
REQ-025 flush_i SHALL clear all busy bits and starve, overriding any same-cycle set; rr unchanged.
REQ-026 hazard_o = busy[rs1_i] | busy[rs2_i] | busy[rd_i], index 0 contributing 0; reflects registered busy only (no same-cycle bypass).

Reset
REQ-027 rst_n low SHALL asynchronously clear busy, starve, rr=0; all outputs read 0 while rst_n low and valids low.
REQ-028 A request pending across reset SHALL be dropped; requesters re-present after reset.

Structure
REQ-029 Requester-index encoding, STARVE_MAX default and the 5-bit register-address width SHALL reside in the shared defines include.
REQ-030 One sub-module, regs_scoreboard (busy vector, set/clear/flush, hazard lookup), SHALL be instantiated; arbitration stays in regs_wb_arb.

Verification
REQ-031 ex_we_i=1 (x5, 0x11) with lsu_valid_i=1 -> we_o=1, waddr_o=5, wdata_o=0x11, lsu_ready_o=0; next cycle lsu granted.
REQ-032 lsu and mdu valid continuously 4 cycles from reset -> grants lsu, mdu, lsu, mdu.
REQ-033 lsu+mdu valid continuously, dbg valid -> dbg denied 4 cycles, granted in 5th, starve returns 0.
REQ-034 issue_lock_i x7; next cycle rs1_i=7 -> hazard_o=1; mdu write x7 accepted -> busy_o[7]=0, hazard_o=0 following cycle.
REQ-035 Same cycle issue_lock_i x9 and lsu write x9 accepted -> busy_o[9]=1; repeat with flush_i=1 -> busy_o=0.
REQ-036 dbg write x0 value 0xDEAD -> dbg_ready_o=1, we_o=0; rst_n pulsed mid-sequence -> busy_o=0, rr=0 immediately.

Source files
------------

// File: rtl/regs_wb_arb_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
// Holds requester grant encoding, the address width and the dbg starvation limit.
package regs_wb_arb_pkg;

  localparam int AW             = 5;
  localparam int NREG           = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef logic [AW-1:0] raddr_t;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_EX,
    GNT_LSU,
    GNT_MDU,
    GNT_DBG
  } gnt_e;

  function automatic logic [NREG-1:0] onehot(raddr_t a);
    return NREG'(1) << a;
  endfunction

endpackage

// File: rtl/regs_wb_arb_if.sv
// Writeback bus bundle: ex/lsu/mdu/dbg requests plus the single regfile write port.
// master drives requests and sees grants/write port; slave is the arbiter.
interface regs_wb_arb_if;
  import regs_wb_arb_pkg::*;

  logic        ex_we_i;
  raddr_t      ex_waddr_i;
  logic [31:0] ex_wdata_i;

  logic        lsu_valid_i;
  raddr_t      lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_ready_o;

  logic        mdu_valid_i;
  raddr_t      mdu_waddr_i;
  logic [31:0] mdu_wdata_i;
  logic        mdu_ready_o;

  logic        dbg_valid_i;
  raddr_t      dbg_waddr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ready_o;

  logic        we_o;
  raddr_t      waddr_o;
  logic [31:0] wdata_o;

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output mdu_valid_i, mdu_waddr_i, mdu_wdata_i,
    output dbg_valid_i, dbg_waddr_i, dbg_wdata_i,
    input  lsu_ready_o, mdu_ready_o, dbg_ready_o,
    input  we_o, waddr_o, wdata_o
  );

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  mdu_valid_i, mdu_waddr_i, mdu_wdata_i,
    input  dbg_valid_i, dbg_waddr_i, dbg_wdata_i,
    output lsu_ready_o, mdu_ready_o, dbg_ready_o,
    output we_o, waddr_o, wdata_o
  );

endinterface

// File: rtl/regs_scoreboard.sv
// Busy-register scoreboard: set on issue, clear on writeback, flush clears all.
// Ports: set/clr strobes+addr, flush_i, rs1/rs2/rd query, busy_o vector, hazard_o.
module regs_scoreboard
  import regs_wb_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_i,
  input  raddr_t          set_addr_i,
  input  logic            clr_i,
  input  raddr_t          clr_addr_i,
  input  logic            flush_i,
  input  raddr_t          rs1_i,
  input  raddr_t          rs2_i,
  input  raddr_t          rd_i,
  output logic [NREG-1:0] busy_o,
  output logic            hazard_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_m, clr_m;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (set_i) set_m = onehot(set_addr_i);
    if (clr_i) clr_m = onehot(clr_addr_i);
    // set applied after clear so a same-cycle set wins
    busy_d    = (busy_q & ~clr_m) | set_m;
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // bit 0 is never set, so x0 never contributes
  assign hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rd_i];
  assign busy_o   = busy_q;

endmodule

// File: rtl/regs_wb_arb.sv
// Regfile writeback arbiter: ex > lsu/mdu round-robin > dbg, with dbg starvation promotion.
// Ports: clk, rst_n, wb (slave bus), issue/flush/operand query, hazard_o, busy_o.
module regs_wb_arb
  import regs_wb_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  regs_wb_arb_if.slave    wb,
  input  logic            issue_lock_i,
  input  raddr_t          issue_addr_i,
  input  raddr_t          rs1_i,
  input  raddr_t          rs2_i,
  input  raddr_t          rd_i,
  input  logic            flush_i,
  output logic            hazard_o,
  output logic [NREG-1:0] busy_o
);

  localparam int SW = $clog2(STARVE_MAX) + 1;

  logic [SW-1:0] starve_q, starve_d;
  logic          rr_q, rr_d;
  logic          dbg_prom;
  gnt_e          gnt;

  assign dbg_prom = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    gnt = GNT_NONE;
    if (wb.ex_we_i)
      gnt = GNT_EX;
    else if (wb.dbg_valid_i && dbg_prom)
      gnt = GNT_DBG;
    else if (wb.lsu_valid_i && wb.mdu_valid_i)
      gnt = rr_q ? GNT_MDU : GNT_LSU;
    else if (wb.lsu_valid_i)
      gnt = GNT_LSU;
    else if (wb.mdu_valid_i)
      gnt = GNT_MDU;
    else if (wb.dbg_valid_i)
      gnt = GNT_DBG;
  end

  always_comb begin
    wb.lsu_ready_o = 1'b0;
    wb.mdu_ready_o = 1'b0;
    wb.dbg_ready_o = 1'b0;
    wb.waddr_o     = '0;
    wb.wdata_o     = '0;
    unique case (gnt)
      GNT_EX: begin
        wb.waddr_o = wb.ex_waddr_i;
        wb.wdata_o = wb.ex_wdata_i;
      end
      GNT_LSU: begin
        wb.lsu_ready_o = 1'b1;
        wb.waddr_o     = wb.lsu_waddr_i;
        wb.wdata_o     = wb.lsu_wdata_i;
      end
      GNT_MDU: begin
        wb.mdu_ready_o = 1'b1;
        wb.waddr_o     = wb.mdu_waddr_i;
        wb.wdata_o     = wb.mdu_wdata_i;
      end
      GNT_DBG: begin
        wb.dbg_ready_o = 1'b1;
        wb.waddr_o     = wb.dbg_waddr_i;
        wb.wdata_o     = wb.dbg_wdata_i;
      end
      default: ;
    endcase
  end

  assign wb.we_o = (gnt != GNT_NONE) && (wb.waddr_o != '0);

  always_comb begin
    rr_d     = rr_q;
    starve_d = starve_q;
    if (gnt == GNT_LSU) rr_d = 1'b1;
    if (gnt == GNT_MDU) rr_d = 1'b0;
    if (flush_i || !wb.dbg_valid_i || gnt == GNT_DBG)
      starve_d = '0;
    else if (!dbg_prom)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      rr_q     <= rr_d;
      starve_q <= starve_d;
    end
  end

  regs_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (issue_lock_i),
    .set_addr_i (issue_addr_i),
    .clr_i      (gnt == GNT_LSU || gnt == GNT_MDU),
    .clr_addr_i (wb.waddr_o),
    .flush_i    (flush_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rd_i       (rd_i),
    .busy_o     (busy_o),
    .hazard_o   (hazard_o)
  );

endmodule
